reg_to_obi_bridge: RTL and testbench



---
 rtl/obi_pkg.sv | 19 +
 rtl/reg_pkg.sv | 19 +
 rtl/reg_to_obi_pkg.sv | 15 +
 rtl/reg_to_obi_bridge.sv | 148 ++++++++++++++
 tb/tb_reg_to_obi_bridge.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_pkg.sv
// OBI initiator request/response bundles.
// Address/data phases are 32 bits wide.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/reg_pkg.sv
// Register-bus request/response bundles.
// Single-beat, 32-bit data with byte strobes.
package reg_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } reg_rsp_t;

endpackage

// File: rtl/reg_to_obi_pkg.sv
// Shared types for the register-to-OBI bridge.
// State encoding and default error read data.
package reg_to_obi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } reg_to_obi_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADCAB1E;

endpackage

// File: rtl/reg_to_obi_bridge.sv
// Register-bus to OBI initiator bridge, one transaction in flight.
// A response timeout keeps a silent slave from hanging the register bus.
module reg_to_obi_bridge
  import reg_to_obi_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 255,
  parameter logic [31:0] ErrRdata      = ERR_RDATA_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  reg_pkg::reg_req_t   reg_req_i,
  output reg_pkg::reg_rsp_t   reg_rsp_o,
  output obi_pkg::obi_req_t   obi_req_o,
  input  obi_pkg::obi_resp_t  obi_resp_i,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int unsigned CntW =
    (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] CntLast =
    (TimeoutCycles == 0) ? '0 : CntW'(TimeoutCycles - 1);

  reg_to_obi_state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            drain_q, drain_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            error_q, error_d;
  logic            expire;
  logic            timeout;

  assign expire = (TimeoutCycles != 0) && (cnt_q == CntLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reg_req_i.valid) begin
          we_d    = reg_req_i.write;
          be_d    = reg_req_i.write ? reg_req_i.wstrb : 4'hF;
          addr_d  = reg_req_i.addr & ~32'h3;
          wdata_d = reg_req_i.wdata;
          state_d = REQ;
        end
      end
      REQ: begin
        if (obi_resp_i.gnt) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
        // A response in the expiry cycle still counts as on time
        if (obi_resp_i.rvalid) begin
          rdata_d = we_q ? '0 : obi_resp_i.rdata;
          error_d = 1'b0;
          state_d = DONE;
        end else if (expire) begin
          rdata_d = ErrRdata;
          error_d = 1'b1;
          timeout = 1'b1;
          drain_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = drain_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (obi_resp_i.rvalid) begin
          drain_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign obi_req_o.req   = (state_q == REQ);
  assign obi_req_o.we    = we_q;
  assign obi_req_o.be    = be_q;
  assign obi_req_o.addr  = addr_q;
  assign obi_req_o.wdata = wdata_q;

  assign reg_rsp_o.ready = (state_q == DONE);
  assign reg_rsp_o.error = error_q;
  assign reg_rsp_o.rdata = rdata_q;

  assign busy_o    = (state_q != IDLE);
  assign timeout_o = timeout;

`ifndef SYNTHESIS
  a_req_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (obi_req_o.req && !obi_resp_i.gnt) |=> $stable(obi_req_o)
  ) else $error("obi request changed before grant");

  a_rvalid_legal: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    obi_resp_i.rvalid |-> (state_q inside {WAIT, DRAIN})
  ) else $error("rvalid with no outstanding transaction");
`endif

endmodule

// File: tb/tb_reg_to_obi_bridge.sv
// Directed bench for reg_to_obi_bridge with a response scoreboard.
// OBI slave behaviour is driven cycle by cycle from the stimulus.
module tb_reg_to_obi_bridge;
  import reg_pkg::*;
  import obi_pkg::*;

  typedef struct packed {
    logic        error;
    logic [31:0] rdata;
  } exp_t;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  reg_req_t  rq = '0;
  reg_rsp_t  rs;
  obi_req_t  oq;
  obi_resp_t op = '0;
  logic      busy;
  logic      tmo;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;

  reg_to_obi_bridge #(
    .TimeoutCycles(8),
    .ErrRdata(32'hBADCAB1E)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .reg_req_i(rq),
    .reg_rsp_o(rs),
    .obi_req_o(oq),
    .obi_resp_i(op),
    .busy_o(busy),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every ready pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rs.ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_rdata", rs.rdata, e.rdata);
        chk("sb_error", 32'(rs.error), 32'(e.error));
      end
    end
  end

  task automatic xact(input string tag, input logic w,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input int gstall,
                      input int rstall, input logic [31:0] rd,
                      input logic exp_err, input int exp_lat,
                      input int exp_tmo);
    int n = 0;
    int reqs = 0;
    int waits = 0;
    int tmos = 0;
    int tmo_at = -1;
    bit granted = 0;
    bit done = 0;
    logic [31:0] exp_rd;
    exp_rd = exp_err ? 32'hBADCAB1E : (w ? 32'h0 : rd);
    rq.valid = 1'b1;
    rq.write = w;
    rq.addr  = a;
    rq.wdata = wd;
    rq.wstrb = ws;
    op = '0;
    sb.push_back('{error: exp_err, rdata: exp_rd});
    while (!done && n < 100) begin
      step();
      n++;
      op = '0;
      if (granted && !rs.ready) begin
        if (waits == rstall) begin
          op.rvalid = 1'b1;
          op.rdata  = rd;
        end
        waits++;
      end
      if (oq.req) begin
        rq.valid = 1'b0;
        reqs++;
        chk({tag, "_addr"}, oq.addr, a & ~32'h3);
        chk({tag, "_be"}, 32'(oq.be), w ? 32'(ws) : 32'hF);
        chk({tag, "_we"}, 32'(oq.we), 32'(w));
        if (w) chk({tag, "_wdata"}, oq.wdata, wd);
        if (reqs > gstall) begin
          op.gnt  = 1'b1;
          granted = 1;
        end
      end
      #1;
      if (tmo) begin
        tmos++;
        tmo_at = n;
      end
      if (rs.ready) begin
        done = 1;
        chk({tag, "_latency"}, n, exp_lat);
      end
    end
    chk({tag, "_completed"}, 32'(done), 32'd1);
    chk({tag, "_req_cycles"}, reqs, gstall + 1);
    chk({tag, "_timeout_pulses"}, tmos, exp_tmo);
    if (exp_tmo != 0) chk({tag, "_timeout_cycle"}, tmo_at, exp_lat - 1);
    op = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int reqs;
    int readies;
    bit bad;

    #12;
    chk("rst_req", 32'(oq.req), 0);
    chk("rst_we", 32'(oq.we), 0);
    chk("rst_be", 32'(oq.be), 0);
    chk("rst_addr", oq.addr, 0);
    chk("rst_wdata", oq.wdata, 0);
    chk("rst_ready", 32'(rs.ready), 0);
    chk("rst_error", 32'(rs.error), 0);
    chk("rst_rdata", rs.rdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(tmo), 0);
    step();
    rst_n = 1'b1;
    step();

    xact("read", 1'b0, 32'h2000_0006, 32'h0, 4'h0, 0, 0,
         32'hDEAD_BEEF, 1'b0, 3, 0);
    step();
    chk("read_ready_one_cycle", 32'(rs.ready), 0);
    chk("read_idle", 32'(busy), 0);

    xact("write", 1'b1, 32'h1000_0008, 32'h1234_5678, 4'b0011, 5, 0,
         32'hFFFF_FFFF, 1'b0, 8, 0);
    step();

    // three reads with valid held: responses every 4 cycles
    rq.valid = 1'b1;
    rq.write = 1'b0;
    rq.addr  = 32'h1000_0000;
    op = '0;
    for (int k = 1; k <= 3; k++) begin
      sb.push_back('{error: 1'b0, rdata: 32'hA000_0000 + 32'(k)});
    end
    n = 0;
    reqs = 0;
    readies = 0;
    while (readies < 3 && n < 30) begin
      step();
      n++;
      op = '0;
      if (oq.req) begin
        reqs++;
        op.gnt = 1'b1;
        if (reqs == 3) rq.valid = 1'b0;
      end else if (busy && !rs.ready) begin
        op.rvalid = 1'b1;
        op.rdata  = 32'hA000_0000 + 32'(reqs);
      end
      if (rs.ready) begin
        readies++;
        chk("b2b_ready_cycle", n, 4 * readies - 1);
      end
    end
    op = '0;
    chk("b2b_readies", readies, 3);
    chk("b2b_reqs", reqs, 3);
    step();
    chk("b2b_idle", 32'(busy), 0);

    xact("timeout", 1'b0, 32'h2000_0100, 32'h0, 4'h0, 0, -1,
         32'h0, 1'b1, 10, 1);

    // next request waits behind the drain of the late response
    rq.valid = 1'b1;
    rq.write = 1'b0;
    rq.addr  = 32'h3000_0010;
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (oq.req || rs.ready || !busy) bad = 1;
    end
    chk("drain_holds_request", 32'(bad), 0);
    op.rvalid = 1'b1;
    op.rdata  = 32'h5555_5555;
    step();
    op = '0;
    chk("drain_exit_idle", 32'(busy), 0);
    xact("after_drain", 1'b0, 32'h3000_0010, 32'h0, 4'h0, 0, 0,
         32'h0BAD_F00D, 1'b0, 3, 0);
    step();

    xact("race", 1'b0, 32'h2000_0200, 32'h0, 4'h0, 0, 7,
         32'hCAFE_0001, 1'b0, 10, 0);
    step();
    chk("race_no_drain", 32'(busy), 0);

    // reset while in REQ
    rq.valid = 1'b1;
    rq.write = 1'b0;
    rq.addr  = 32'h0000_0004;
    step();
    rq.valid = 1'b0;
    chk("rstreq_in_req", 32'(oq.req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstreq_req", 32'(oq.req), 0);
    chk("rstreq_ready", 32'(rs.ready), 0);
    chk("rstreq_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;

    // reset while in WAIT
    rq.valid = 1'b1;
    step();
    rq.valid = 1'b0;
    op.gnt = 1'b1;
    step();
    op = '0;
    chk("rstwait_in_wait", 32'(busy && !oq.req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstwait_req", 32'(oq.req), 0);
    chk("rstwait_ready", 32'(rs.ready), 0);
    chk("rstwait_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;
    step();

    xact("post_reset", 1'b0, 32'h4000_000C, 32'h0, 4'h0, 1, 2,
         32'h7777_1234, 1'b0, 6, 0);
    step();
    step();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
